// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch front end.
// Issues sequential word reads over a req/gnt + rvalid bus, buffers returned
// words in a first-word-fall-through queue and presents {instruction, pc} to
// decode over valid/ready. A redirect flushes the queue, retargets both the
// request and response PC, and discards every response still in flight.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic              active;
    logic [31:0]       fetch_pc;
    logic [31:0]       rsp_pc;
    logic [31:0]       redirect_target;
    logic [CNT_W-1:0]  count;
    logic [OUT_W-1:0]  outstanding;
    logic [OUT_W-1:0]  outstanding_next;
    logic [OUT_W-1:0]  discard;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [SUM_W-1:0]  credit_used;
    logic              issue;
    logic              rsp_accept;
    logic              push;
    logic              pop;
    logic [31:0]       q_instr [FIFO_DEPTH];
    logic [31:0]       q_pc    [FIFO_DEPTH];

    // Issue credit, handshake qualifiers and queue-head presentation
    always_comb begin
        redirect_target  = redirect_pc & 32'hFFFF_FFFC;
        credit_used      = SUM_W'(count) + SUM_W'(outstanding);
        imem_req         = active && !redirect
                           && (outstanding < OUT_W'(MAX_OUTSTANDING))
                           && (credit_used < SUM_W'(FIFO_DEPTH));
        imem_addr        = fetch_pc;
        issue            = imem_req && imem_gnt;
        rsp_accept       = imem_rvalid && (outstanding != '0);
        push             = rsp_accept && !redirect && (discard == '0);
        instr_valid      = (count != '0) && !redirect;
        pop              = instr_valid && instr_ready;
        outstanding_next = outstanding + OUT_W'(issue) - OUT_W'(rsp_accept);
        instruction      = '0;
        instr_pc         = '0;
        if (count != '0) begin
            instruction = q_instr[rd_ptr];
            instr_pc    = q_pc[rd_ptr];
        end
    end

    // Fetch/response PCs, credit counters, discard count and queue pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active      <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            active      <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                discard  <= outstanding_next;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_accept && (discard != '0)) begin
                    discard <= discard - OUT_W'(1);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Queue storage; entries are only observed while counted, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= rsp_pc;
        end
    end

    // A response with nothing outstanding is a bus protocol violation
    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order memory responder.
// Memory data for address A is ~A, so expected instructions are hand-derived.
module tb_fetch_prefetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int          checks   = 0;
    int          failures = 0;
    logic        gnt_en;
    logic        rsp_en;
    logic [31:0] pending [$];

    fetch_prefetch_unit #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response and grant, log accepted requests,
    // then land 1 time unit after the next falling edge.
    task automatic step();
        logic [31:0] a;
        imem_gnt = gnt_en;
        if (rsp_en && pending.size() != 0) begin
            a           = pending.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = ~a;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        if (imem_req && imem_gnt) pending.push_back(imem_addr);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Assert reset (asynchronously), check reset outputs, release; returns
    // in the first cycle where the unit may request.
    task automatic do_reset();
        rst         = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pending.delete();
        #1;
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction,      32'd0);
        chk("rst_pc",    instr_pc,         32'd0);
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        gnt_en      = 1'b1;
        rsp_en      = 1'b1;

        // 1: streaming, grant in cycle 1 -> valid in cycle 3
        do_reset();
        chk("t1_req_c1",   32'(imem_req),    32'd1);
        chk("t1_addr_c1",  imem_addr,        32'h0);
        chk("t1_valid_c1", 32'(instr_valid), 32'd0);
        step();
        chk("t1_addr_c2",  imem_addr,        32'h4);
        chk("t1_valid_c2", 32'(instr_valid), 32'd0);
        step();
        chk("t1_valid_c3", 32'(instr_valid), 32'd1);
        chk("t1_pc_c3",    instr_pc,         32'h0);
        chk("t1_instr_c3", instruction,      32'hFFFF_FFFF);
        chk("t1_addr_c3",  imem_addr,        32'h8);
        step();
        chk("t1_pc_c4",    instr_pc,         32'h4);
        chk("t1_instr_c4", instruction,      32'hFFFF_FFFB);
        step();
        chk("t1_pc_c5",    instr_pc,         32'h8);
        chk("t1_instr_c5", instruction,      32'hFFFF_FFF7);

        // 2: decode stalled, queue fills to depth, then drains in order
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        chk("t2_req_full_c5", 32'(imem_req), 32'd0);
        for (int i = 0; i < 6; i++) step();
        chk("t2_req_c11",   32'(imem_req),    32'd0);
        chk("t2_valid_c11", 32'(instr_valid), 32'd1);
        chk("t2_pc_c11",    instr_pc,         32'h0);
        instr_ready = 1'b1;
        step();
        chk("t2_pc_c12",    instr_pc,         32'h4);
        chk("t2_req_c12",   32'(imem_req),    32'd1);
        chk("t2_addr_c12",  imem_addr,        32'h10);
        step();
        chk("t2_pc_c13",    instr_pc,         32'h8);
        step();
        chk("t2_pc_c14",    instr_pc,         32'hC);
        chk("t2_instr_c14", instruction,      32'hFFFF_FFF3);
        step();
        chk("t2_pc_c15",    instr_pc,         32'h10);
        chk("t2_instr_c15", instruction,      32'hFFFF_FFEF);

        // 3: redirect with two reads outstanding; both stale words dropped
        rsp_en = 1'b0;
        do_reset();
        chk("t3_addr_c1", imem_addr, 32'h0);
        step();
        chk("t3_addr_c2", imem_addr, 32'h4);
        step();
        chk("t3_req_cap", 32'(imem_req), 32'd0);
        rsp_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_redir_valid", 32'(instr_valid), 32'd0);
        chk("t3_redir_req",   32'(imem_req),    32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("t3_req_c4",   32'(imem_req),    32'd1);
        chk("t3_addr_c4",  imem_addr,        32'h100);
        chk("t3_valid_c4", 32'(instr_valid), 32'd0);
        step();
        chk("t3_valid_c5", 32'(instr_valid), 32'd0);
        step();
        chk("t3_valid_c6", 32'(instr_valid), 32'd1);
        chk("t3_pc_c6",    instr_pc,         32'h100);
        chk("t3_instr_c6", instruction,      32'hFFFF_FEFF);
        step();
        chk("t3_pc_c7",    instr_pc,         32'h104);
        chk("t3_instr_c7", instruction,      32'hFFFF_FEFB);

        // 4: misaligned redirect while the queue holds an entry
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("t4_redir_valid", 32'(instr_valid), 32'd0);
        chk("t4_redir_req",   32'(imem_req),    32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("t4_addr",     imem_addr,        32'h100);
        chk("t4_req",      32'(imem_req),    32'd1);
        chk("t4_flushed",  32'(instr_valid), 32'd0);
        step();
        chk("t4_valid_c2", 32'(instr_valid), 32'd0);
        step();
        chk("t4_valid_c3", 32'(instr_valid), 32'd1);
        chk("t4_pc_c3",    instr_pc,         32'h100);
        chk("t4_instr_c3", instruction,      32'hFFFF_FEFF);

        // 5: grant withheld; address held, no PC advance
        gnt_en = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("t5_req_hold",  32'(imem_req), 32'd1);
            chk("t5_addr_hold", imem_addr,     32'h0);
            step();
        end
        chk("t5_valid_nognt", 32'(instr_valid), 32'd0);
        gnt_en = 1'b1;
        chk("t5_addr_c6", imem_addr, 32'h0);
        step();
        chk("t5_addr_c7", imem_addr, 32'h4);
        step();
        chk("t5_valid_c8", 32'(instr_valid), 32'd1);
        chk("t5_pc_c8",    instr_pc,         32'h0);
        chk("t5_instr_c8", instruction,      32'hFFFF_FFFF);

        // 6: reset asserted between edges mid-stream, then clean restart
        step();
        chk("t6_pc_pre",  instr_pc,      32'h4);
        chk("t6_req_pre", 32'(imem_req), 32'd1);
        #2;
        do_reset();
        chk("t6_addr_c1",  imem_addr,        32'h0);
        chk("t6_req_c1",   32'(imem_req),    32'd1);
        chk("t6_valid_c1", 32'(instr_valid), 32'd0);
        step();
        chk("t6_valid_c2", 32'(instr_valid), 32'd0);
        step();
        chk("t6_pc_c3",    instr_pc,         32'h0);
        chk("t6_instr_c3", instruction,      32'hFFFF_FFFF);
        step();
        chk("t6_pc_c4",    instr_pc,         32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
